// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//   Generates one PWM waveform per servo (4 servos). Each frame lasts PERIOD
//   clocks. At every frame start the commanded servo (ServoNum) takes a new
//   high-time. That high-time is first clamped to [DUTY_MIN, DUTY_MAX]. All
//   other servos keep their last high-time. A one-cycle pulse marks each
//   frame wrap, and the sequencer counts these pulses.
//
// Ports
//   clk                  system clock
//   ResetN               asynchronous active-low reset
//   EnablePWM            run enable; low forces the frame counter to 0 and
//                        drives the outputs low
//   ServoNum[1:0]        servo whose high-time is being commanded
//   ActiveServoDuty      commanded high-time in clocks (sampled at frame start)
//   PWMOut[3:0]          registered PWM outputs, one bit per servo
//   ActivePeriodFinished registered one-cycle pulse on each frame wrap
//   DutyClamped          registered; 1 if the last duty load was clamped
module servo_pwm_driver #(
  parameter int unsigned PERIOD    = 2_000_000,
  parameter int unsigned DUTY_W    = 21,
  parameter int unsigned DUTY_MIN  = 50_000,
  parameter int unsigned DUTY_MAX  = 250_000,
  parameter int unsigned DUTY_INIT = 150_000
) (
  input  logic              clk,
  input  logic              ResetN,
  input  logic              EnablePWM,
  input  logic [1:0]        ServoNum,
  input  logic [DUTY_W-1:0] ActiveServoDuty,
  output logic [3:0]        PWMOut,
  output logic              ActivePeriodFinished,
  output logic              DutyClamped
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] D_MIN    = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] D_MAX    = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] D_INIT   = DUTY_W'(DUTY_INIT);

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] value);
    if (value < D_MIN)      clamp_duty = D_MIN;
    else if (value > D_MAX) clamp_duty = D_MAX;
    else                    clamp_duty = value;
  endfunction

  function automatic logic duty_out_of_range(input logic [DUTY_W-1:0] value);
    duty_out_of_range = (value < D_MIN) || (value > D_MAX);
  endfunction

  logic [DUTY_W-1:0] counter;
  logic [DUTY_W-1:0] duty [4];
  logic [DUTY_W-1:0] eff  [4];
  logic [DUTY_W-1:0] load_val;
  logic              load_clamped;
  logic              frame_start;
  logic              frame_wrap;

  // Frame control and load-value preparation (combinational, ahead of the output registers)
  assign frame_start  = EnablePWM && (counter == '0);
  assign frame_wrap   = EnablePWM && (counter == CNT_LAST);
  assign load_val     = clamp_duty(ActiveServoDuty);
  assign load_clamped = duty_out_of_range(ActiveServoDuty);

  // The servo being loaded compares against its new value in the same
  // cycle. This makes its high-time begin exactly one clock after frame
  // start, with no runt pulse from the old value.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff[i] = duty[i];
      if (frame_start && (ServoNum == 2'(i))) eff[i] = load_val;
    end
  end

  // Output register stage: counter, duty store and registered outputs
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      counter              <= '0;
      PWMOut               <= '0;
      ActivePeriodFinished <= 1'b0;
      DutyClamped          <= 1'b0;
      for (int i = 0; i < 4; i++) duty[i] <= D_INIT;
    end else if (!EnablePWM) begin
      // Idle: a partial frame is discarded. Duty values and the clamp flag are kept.
      counter              <= '0;
      PWMOut               <= '0;
      ActivePeriodFinished <= 1'b0;
    end else begin
      counter              <= frame_wrap ? '0 : counter + CNT_ONE;
      ActivePeriodFinished <= frame_wrap;
      for (int i = 0; i < 4; i++) PWMOut[i] <= (counter < eff[i]);
      if (frame_start) begin
        duty[ServoNum] <= load_val;
        DutyClamped    <= load_clamped;
      end
    end
  end

endmodule
